// File: rtl/counter_pkg.sv
// Shared types for the modulo-N counter.
//   cnt_mode_e  : run mode select (WRAP, ONESHOT, PINGPONG; RSVD decodes as WRAP)
//   cnt_state_e : run/halt state (HALT is reachable only in ONESHOT)
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP     = 2'b00,
    ONESHOT  = 2'b01,
    PINGPONG = 2'b10,
    RSVD     = 2'b11
  } cnt_mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with enable, direction, synchronous clear, parallel load and three run
// modes (wrap, one-shot, ping-pong).
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   en       : count enable, one step per cycle
//   up_dn    : 1 = count up, 0 = count down (ignored in ping-pong)
//   mode     : cnt_mode_e run mode
//   clear    : synchronous clear to the start value for the current direction
//   load     : parallel load strobe; load_val is the value loaded
//   count    : registered count, always in 0..MODULUS-1
//   tc       : combinational terminal-count flag
//   done     : sticky one-shot completion flag
//   load_err : one-cycle pulse after a load of an out-of-range value
module mod_n_counter
  import counter_pkg::*;
#(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned CW      = $clog2(MODULUS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          up_dn,
  input  logic [1:0]    mode,
  input  logic          clear,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count,
  output logic          tc,
  output logic          done,
  output logic          load_err
);

  localparam logic [CW-1:0] MaxCnt = CW'(MODULUS - 1);

  cnt_mode_e  mode_e;
  cnt_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic dir_up_q, dir_up_d;
  logic done_q, done_d;
  logic load_err_q, load_err_d;

  logic going_up;
  logic at_term;
  logic load_ok;
  logic [CW-1:0] inc_val;
  logic [CW-1:0] dec_val;

  assign mode_e = cnt_mode_e'(mode);

  // Ping-pong follows its own internal direction; the other modes follow up_dn.
  assign going_up = (mode_e == PINGPONG) ? dir_up_q : up_dn;
  assign at_term  = going_up ? (count_q == MaxCnt) : (count_q == '0);
  assign load_ok  = (32'(load_val) < MODULUS);

  // Wrap explicitly at MODULUS so non-power-of-two moduli never leave the legal range.
  assign inc_val = (count_q == MaxCnt) ? '0 : count_q + CW'(1);
  assign dec_val = (count_q == '0) ? MaxCnt : count_q - CW'(1);

  assign tc = en && (state_q == RUN) && at_term;

  always_comb begin
    count_d    = count_q;
    dir_up_d   = dir_up_q;
    state_d    = state_q;
    done_d     = done_q;
    load_err_d = 1'b0;

    if (clear) begin
      count_d  = (up_dn || (mode_e == PINGPONG)) ? '0 : MaxCnt;
      dir_up_d = 1'b1;
      state_d  = RUN;
      done_d   = 1'b0;
    end else if (load) begin
      if (load_ok) begin
        count_d = load_val;
      end else begin
        count_d    = MaxCnt;
        load_err_d = 1'b1;
      end
      dir_up_d = 1'b1;
      state_d  = RUN;
      done_d   = 1'b0;
    end else if (en && (state_q == RUN)) begin
      case (mode_e)
        PINGPONG: begin
          // Bounce off each endpoint after holding it for one cycle.
          if (dir_up_q) begin
            if (count_q == MaxCnt) begin
              count_d  = count_q - CW'(1);
              dir_up_d = 1'b0;
            end else begin
              count_d = count_q + CW'(1);
            end
          end else begin
            if (count_q == '0) begin
              count_d  = CW'(1);
              dir_up_d = 1'b1;
            end else begin
              count_d = count_q - CW'(1);
            end
          end
        end
        ONESHOT: begin
          if (at_term) begin
            state_d = HALT;
            done_d  = 1'b1;
          end else begin
            count_d = up_dn ? inc_val : dec_val;
          end
        end
        default: begin
          count_d = up_dn ? inc_val : dec_val;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      dir_up_q   <= 1'b1;
      state_q    <= RUN;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      dir_up_q   <= dir_up_d;
      state_q    <= state_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign done     = done_q;
  assign load_err = load_err_q;

endmodule

// File: doc/mod_n_counter.md
Name: mod_n_counter

Overview:
- Parametrised modulo-N counter, successor to the free-running n-bit counter.
- Counts 0..MODULUS-1 with enable, up/down direction, synchronous clear and parallel load.
- Three run modes: wrap, one-shot and ping-pong. Provides terminal-count and done flags.
- Used as a timebase/sequencer primitive by lab datapaths and display/scan logic.

Parameters:
- MODULUS, 10, number of count states; legal count range is 0..MODULUS-1; must be >= 2.
- CW, $clog2(MODULUS), count width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; count advances one step per cycle while high.
- up_dn  in  1  direction: 1 = up, 0 = down. Used in wrap and one-shot modes; ignored in ping-pong.
- mode  in  2  cnt_mode_e: 00 WRAP, 01 ONESHOT, 10 PINGPONG, 11 reserved (behaves as WRAP).
- clear  in  1  synchronous clear to start value.
- load  in  1  parallel load strobe.
- load_val  in  CW  value to load.
- count  out  CW  current count (registered).
- tc  out  1  terminal count (combinational): high when en=1, not halted, and count is at the terminal value for the current direction (MODULUS-1 going up, 0 going down).
- done  out  1  ONESHOT completion flag (registered, sticky).
- load_err  out  1  one-cycle registered pulse when load_val >= MODULUS.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset state: count=0, done=0, load_err=0, internal dir=up, FSM=RUN.
- Priority per cycle: reset > clear > load > en. Lower-priority actions are ignored in that cycle.
- clear: count=0 if up_dn=1 or mode=PINGPONG; count=MODULUS-1 if down in WRAP/ONESHOT. Also done=0, FSM=RUN, dir=up.
- load: count=load_val if load_val < MODULUS. Otherwise count=MODULUS-1 and load_err=1 next cycle. Also done=0, FSM=RUN, dir=up. load_err is 0 in every other cycle.
- FSM states: RUN and HALT. HALT is entered only in ONESHOT and exited only via reset, clear or load.
- en=0: count holds; tc=0.
- WRAP mode, RUN, en=1:
  - up: count+1, with MODULUS-1 -> 0.
  - down: count-1, with 0 -> MODULUS-1.
  - Arithmetic is modulo MODULUS, not 2^CW.
- ONESHOT mode, RUN, en=1: steps as in WRAP. At the terminal value, count stays put, FSM -> HALT and done=1 from the next cycle.
- HALT: count frozen and tc=0 regardless of en, up_dn or mode changes.
- PINGPONG mode, en=1:
  - dir=up: count+1; at MODULUS-1 it steps to MODULUS-2 and dir flips to down.
  - dir=down: count-1; at 0 it steps to 1 and dir flips to up.
  - Endpoints are held for exactly one cycle each. Full period is 2*(MODULUS-1) cycles.
- Mode change mid-run: takes effect on the next enabled step from the current count. dir is kept but only used in PINGPONG. A change out of ONESHOT does not leave HALT.
- up_dn change mid-run: takes effect on the next step; no glitch on count.
- Non-power-of-two MODULUS: count never takes values >= MODULUS under any input sequence.
- MODULUS=2: PINGPONG toggles 0,1,0,1; tc is high every enabled cycle.

Decomposition:
- counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_e {WRAP, ONESHOT, PINGPONG, RSVD};
  - typedef enum logic {RUN, HALT} cnt_state_e;
- Single module; no sub-module. Next-count logic lives in one always_comb block, registers in one always_ff block.

Test Plan (MODULUS=10, CW=4):
- Reset, then WRAP up with en=1 for 12 cycles -> count 0..9,0,1; tc high only when count=9; after reset, count=0, done=0.
- WRAP down after clear -> count starts at 9, then 8..0,9; tc high at count=0. en low for 3 cycles mid-run -> count holds, tc=0.
- ONESHOT up from load_val=7 -> count 7,8,9,9,...; done=1 from the cycle after 9 and stays set; en toggling and up_dn=0 leave count at 9; a clear returns to 0 with done=0.
- PINGPONG from reset -> 0..9,8..0,1,...; each endpoint appears once per pass; period 18 cycles.
- load_val=12 -> count=9 and load_err pulses for exactly one cycle. load and clear in the same cycle -> clear wins (count=0). reset with load in the same cycle -> count=0, load_err=0.
- Random stimulus for 10k cycles with a scoreboard model -> count < 10 at all times and matches the model every cycle.
